prbs13_checker: RTL and testbench
=================================

# prbs13_checker

Receive-side companion to the 13-bit LFSR generator. It consumes the stream of 13-bit pseudo-random words, self-synchronises to the sequence, and declares lock. It then flags and counts every word that departs from the predicted sequence, and drops lock after sustained mismatch. It sits at the far end of any path carrying generator output, for link and datapath integrity checking.

## Interface
- LOCK_CNT, 4: consecutive correct predictions in VERIFY required to enter LOCKED (range 1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force return to HUNT (range 1..15).
- ERR_W, 16: width of the error counter.

- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is synchronous to clock.
- valid  in  1  rnd_in carries a new word this cycle. This is the counterpart of the generator's change/advance.
- rnd_in  in  13  received word.
- clear  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED.
- error  out  1  one-cycle pulse for each mismatched word while LOCKED.
- err_count  out  ERR_W  saturating count of mismatches seen in LOCKED.
- state  out  2  HUNT=0, VERIFY=1, LOCKED=2. The encoding 3 is unused and decodes to HUNT.

## Operation
- Sequence definition: next(x) = {x[11:0], x[12]^x[3]^x[2]^x[0]}. This is the Fibonacci form of x^13+x^4+x^3+x+1, with period 8191. The all-zero word is illegal.
- Internal registers: expected[12:0], match_cnt[3:0], miss_cnt[3:0].
- Cycles with valid=0 change no state. error is 0 on those cycles.
- **HUNT**
  - On valid with rnd_in≠0: expected<=next(rnd_in), match_cnt<=0, go to VERIFY.
  - On valid with rnd_in=0: stay in HUNT.
- **VERIFY**
  - On valid with rnd_in==expected: match_cnt++ and expected<=next(rnd_in). If match_cnt+1==LOCK_CNT, go to LOCKED, set locked=1 and miss_cnt<=0.
  - On mismatch with rnd_in≠0: reseed with expected<=next(rnd_in) and match_cnt<=0. Stay in VERIFY, no error, no count.
  - On mismatch with rnd_in=0: go to HUNT.
- **LOCKED**
  - The prediction free-runs: expected<=next(expected) on every valid, whatever rnd_in holds. A single corrupted word therefore costs exactly one error.
  - On match: miss_cnt<=0.
  - On mismatch: error=1 and err_count++ (saturates at all-ones), miss_cnt++. If miss_cnt+1==LOSS_CNT, go to HUNT and clear locked.
  - rnd_in=0 is treated as an ordinary mismatch.
- **clear**
  - err_count<=0.
  - If clear coincides with a counted mismatch, clear wins and err_count=0 next cycle. The error pulse still fires.
  - clear has no effect on the state machine.
- **Reset values:** state=HUNT, expected=0, match_cnt=0, miss_cnt=0, locked=0, error=0, err_count=0.
- **Reset mid-operation:** all state is lost. Lock must be re-acquired from HUNT.

## Timing
- All outputs are registered.
- For a word sampled on edge k, error, err_count, locked and state reflect it after edge k.
- Minimum lock latency: 1 seeding word plus LOCK_CNT matching words. locked rises on the edge that samples the LOCK_CNT-th match.
- Minimum loss latency: LOSS_CNT consecutive mismatching valid words. locked falls on the edge that samples the last of them. That same edge also pulses error and counts the word.
- valid may toggle arbitrarily; gaps between words are tolerated in every state.
- Back-to-back valid at full clock rate is supported; there is no backpressure.

## Test plan
- **Lock acquisition:** after reset, drive valid each cycle with 0001, 0003, 0007, 000E, 001C (hex) -> state 0→1 after the first word; locked=1 after the 001C edge; error never asserts; err_count=0.
- **Single error:** once locked on the continuing sequence, replace one word with its value XOR 0x0010, then resume the correct sequence -> exactly one error pulse, err_count=1, locked stays 1.
- **Loss of lock:** once locked, drive 3 consecutive wrong nonzero words -> 3 error pulses, err_count=3, locked=0 and state=HUNT after the third.
- **Zero and gap handling:** in HUNT, drive rnd_in=0 with valid -> state stays 0. Then acquire lock with valid deasserted for 5 cycles between each word -> locked=1 after the 5th valid word.
- **Counter behaviour:** with ERR_W=4, inject 20 isolated errors (each followed by correct words) -> err_count saturates at 15. Assert clear on the same cycle as the 21st error -> err_count=0 and error pulses.
- **Reset mid-operation:** while locked with err_count=2, pulse reset low for 1 ns between edges -> all outputs 0 immediately; lock re-acquires normally from HUNT.

Source files
------------

// File: rtl/prbs13_checker_if.sv
// Word stream into the PRBS13 checker and its lock/error status back out.
`timescale 1ns/1ps
interface prbs13_checker_if #(
  parameter int ERR_W = 16
);
  logic             valid;
  logic [12:0]      rnd_in;
  logic             clear;
  logic             locked;
  logic             error;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (output valid, rnd_in, clear, input locked, error, err_count, state);
  modport slave  (input valid, rnd_in, clear, output locked, error, err_count, state);
endinterface

// File: rtl/prbs13_checker.sv
// Self-synchronising PRBS13 checker: seeds from the stream, verifies, locks,
// then flags/counts every mispredicted word; all outputs registered, no backpressure.
`timescale 1ns/1ps
module prbs13_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  prbs13_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [12:0] prbs_next(input logic [12:0] x);
    return {x[11:0], x[12] ^ x[3] ^ x[2] ^ x[0]};
  endfunction

  state_t           state_q;
  logic [12:0]      expected;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;
  logic             locked_q;
  logic             error_q;
  logic [ERR_W-1:0] err_cnt;

  logic             hit;
  logic [3:0]       match_inc;
  logic [3:0]       miss_inc;

  assign hit       = (bus.rnd_in == expected);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      error_q <= 1'b0;
      if (bus.valid) begin
        case (state_q)
          VERIFY: begin
            if (hit) begin
              match_cnt <= match_inc;
              expected  <= prbs_next(bus.rnd_in);
              if (match_inc == 4'(LOCK_CNT)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (bus.rnd_in != 13'd0) begin
              expected  <= prbs_next(bus.rnd_in);
              match_cnt <= '0;
            end else begin
              state_q <= HUNT;
            end
          end
          LOCKED: begin
            // Prediction free-runs so one corrupted word costs exactly one error.
            expected <= prbs_next(expected);
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              error_q  <= 1'b1;
              err_cnt  <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
              miss_cnt <= miss_inc;
              if (miss_inc == 4'(LOSS_CNT)) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
              end
            end
          end
          default: begin
            // Unused encoding 3 behaves as HUNT.
            if (bus.rnd_in != 13'd0) begin
              expected  <= prbs_next(bus.rnd_in);
              match_cnt <= '0;
              state_q   <= VERIFY;
            end
          end
        endcase
      end
      if (bus.clear) begin
        err_cnt <= '0;
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
  assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_prbs13_checker.sv
// Scoreboarded bench for prbs13_checker: a reference model queues expected outputs per driven cycle.
`timescale 1ns/1ps
module tb_prbs13_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int ERR_W    = 4;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic clock;
  logic reset;

  prbs13_checker_if #(.ERR_W(ERR_W)) bus ();

  prbs13_checker #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int st;
    int lk;
    int er;
    int cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_errors;

  int          m_state;
  logic [12:0] m_exp;
  int          m_match;
  int          m_miss;
  int          m_locked;
  int          m_err;
  int          m_cnt;
  logic [12:0] cur;

  function automatic logic [12:0] pn(input logic [12:0] x);
    return {x[11:0], ^(x & 13'h100D)};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_exp    = '0;
    m_match  = 0;
    m_miss   = 0;
    m_locked = 0;
    m_err    = 0;
    m_cnt    = 0;
  endtask

  task automatic model_step(input bit v, input logic [12:0] w, input bit c);
    bit good;
    m_err = 0;
    if (v) begin
      if (m_state == 1) begin
        if (w == m_exp) begin
          m_match++;
          m_exp = pn(w);
          if (m_match == LOCK_CNT) begin
            m_state  = 2;
            m_locked = 1;
            m_miss   = 0;
          end
        end else if (w != 0) begin
          m_exp   = pn(w);
          m_match = 0;
        end else begin
          m_state = 0;
        end
      end else if (m_state == 2) begin
        good  = (w == m_exp);
        m_exp = pn(m_exp);
        if (good) begin
          m_miss = 0;
        end else begin
          m_err = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_state  = 0;
            m_locked = 0;
          end
        end
      end else if (w != 0) begin
        m_exp   = pn(w);
        m_match = 0;
        m_state = 1;
      end
    end
    if (c) m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [12:0] w, input bit c);
    exp_t e;
    exp_t got;
    @(negedge clock);
    bus.valid  = v;
    bus.rnd_in = w;
    bus.clear  = c;
    model_step(v, w, c);
    e.st = m_state; e.lk = m_locked; e.er = m_err; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      chk("state",     int'(bus.state),     got.st);
      chk("locked",    int'(bus.locked),    got.lk);
      chk("error",     int'(bus.error),     got.er);
      chk("err_count", int'(bus.err_count), got.cnt);
    end
  endtask

  task automatic send_good();
    cur = pn(cur);
    drive(1'b1, cur, 1'b0);
  endtask

  task automatic send_bad(input logic [12:0] mask, input bit c);
    cur = pn(cur);
    drive(1'b1, cur ^ mask, c);
  endtask

  logic [12:0] acq [5];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    bus.valid  = 1'b0;
    bus.rnd_in = '0;
    bus.clear  = 1'b0;
    model_reset();
    acq[0] = 13'h0001; acq[1] = 13'h0003; acq[2] = 13'h0007;
    acq[3] = 13'h000E; acq[4] = 13'h001C;

    #12;
    chk("rst_state",  int'(bus.state),     0);
    chk("rst_locked", int'(bus.locked),    0);
    chk("rst_error",  int'(bus.error),     0);
    chk("rst_count",  int'(bus.err_count), 0);
    reset = 1'b1;

    // Lock acquisition from the literal test words
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, acq[i], 1'b0);
      if (i == 0) chk("seed_to_verify", int'(bus.state), 1);
      if (i == 3) chk("not_yet_locked", int'(bus.locked), 0);
    end
    chk("acq_locked", int'(bus.locked), 1);
    chk("acq_count",  int'(bus.err_count), 0);
    cur = 13'h001C;

    // Single corrupted word
    send_good(); send_good();
    send_bad(13'h0010, 1'b0);
    chk("single_err_pulse", int'(bus.error), 1);
    repeat (3) send_good();
    chk("single_err_count", int'(bus.err_count), 1);
    chk("single_err_lock",  int'(bus.locked), 1);

    // Loss of lock
    drive(1'b0, 13'h0, 1'b1);
    chk("clear_idle", int'(bus.err_count), 0);
    send_bad(13'h0100, 1'b0);
    send_bad(13'h0100, 1'b0);
    chk("loss_hold", int'(bus.locked), 1);
    send_bad(13'h0100, 1'b0);
    chk("loss_count",  int'(bus.err_count), 3);
    chk("loss_locked", int'(bus.locked), 0);
    chk("loss_state",  int'(bus.state), 0);

    // VERIFY reseed on mismatch, return to HUNT on zero
    drive(1'b1, 13'h0155, 1'b0);
    drive(1'b1, 13'h0777, 1'b0);
    chk("verify_reseed", int'(bus.state), 1);
    drive(1'b1, 13'h0000, 1'b0);
    chk("verify_zero_hunt", int'(bus.state), 0);

    // Zero in HUNT, then lock with gaps
    drive(1'b1, 13'h0000, 1'b0);
    chk("hunt_zero", int'(bus.state), 0);
    cur = 13'h0ABC;
    drive(1'b1, cur, 1'b0);
    repeat (4) begin
      repeat (5) drive(1'b0, 13'($urandom), 1'b0);
      send_good();
    end
    chk("gap_locked", int'(bus.locked), 1);

    // Saturation and clear priority
    drive(1'b0, 13'h0, 1'b1);
    repeat (20) begin
      send_bad(13'h0010, 1'b0);
      send_good();
    end
    chk("sat_count",  int'(bus.err_count), CNT_MAX);
    chk("sat_locked", int'(bus.locked), 1);
    send_bad(13'h0010, 1'b1);
    chk("clear_wins_count", int'(bus.err_count), 0);
    chk("clear_wins_pulse", int'(bus.error), 1);

    // Asynchronous reset while locked
    send_good();
    send_bad(13'h0010, 1'b0); send_good();
    send_bad(13'h0010, 1'b0); send_good();
    chk("pre_rst_count",  int'(bus.err_count), 2);
    chk("pre_rst_locked", int'(bus.locked), 1);
    #2;
    reset = 1'b0;
    model_reset();
    #0.5;
    chk("async_state",  int'(bus.state),     0);
    chk("async_locked", int'(bus.locked),    0);
    chk("async_error",  int'(bus.error),     0);
    chk("async_count",  int'(bus.err_count), 0);
    #0.5;
    reset = 1'b1;
    cur = 13'h1234;
    drive(1'b1, cur, 1'b0);
    repeat (4) send_good();
    chk("relock", int'(bus.locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
